// File: rtl/audio_tone_gen_if.sv
// Tone generator signal bundle: requested frequency in, tone outputs back.
// The optional mute line exists only when AUDIO_TONE_GEN_MUTE_EN is defined.
interface audio_tone_gen_if #(
    parameter int unsigned FREQ_W = 24
);
    logic [FREQ_W-1:0] freq;
`ifdef AUDIO_TONE_GEN_MUTE_EN
    logic              mute;
`endif
    logic              pulse;
    logic              tick;
    logic              busy;

    modport master (
        output freq,
`ifdef AUDIO_TONE_GEN_MUTE_EN
        output mute,
`endif
        input  pulse,
        input  tick,
        input  busy
    );

    modport slave (
        input  freq,
`ifdef AUDIO_TONE_GEN_MUTE_EN
        input  mute,
`endif
        output pulse,
        output tick,
        output busy
    );
endinterface

// File: rtl/audio_tone_gen.sv
// Square-wave tone generator with iterative half-period divider.
// Optional mute input enabled by macro AUDIO_TONE_GEN_MUTE_EN.
module audio_tone_gen #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned FREQ_W = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [FREQ_W-1:0] i_freq,
`ifdef AUDIO_TONE_GEN_MUTE_EN
    input  logic              i_mute,
`endif
    output logic              o_pulse,
    output logic              o_tick,
    output logic              o_busy
);
    localparam int unsigned DW = FREQ_W + 1;

    typedef enum logic {
        S_IDLE,
        S_DIV
    } state_t;

    state_t            state_q, state_d;
    logic [FREQ_W-1:0] afreq_q, afreq_d;
    logic [DW-1:0]     dvs_q, dvs_d;
    logic [DW-1:0]     rem_q, rem_d;
    logic [31:0]       dvd_q, dvd_d;
    logic [4:0]        bit_q, bit_d;

    logic [DW:0]       shifted;
    logic [DW-1:0]     diff;
    logic              ge;
    logic [31:0]       quo_raw;
    logic [31:0]       result;
    logic              done;
    logic              silence;
    logic              mute;

    logic [31:0]       hp_q, hp_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic              pulse_d, tick_d;
    logic              have_new;
    logic [31:0]       new_val;

`ifdef AUDIO_TONE_GEN_MUTE_EN
    assign mute = i_mute;
`else
    assign mute = 1'b0;
`endif

    // One restoring step; the dividend register doubles as quotient.
    assign shifted = {rem_q, dvd_q[31]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[DW-1:0] - dvs_q;
    assign quo_raw = {dvd_q[30:0], ge};
    assign result  = (quo_raw == 32'd0) ? 32'd1 : quo_raw;
    assign o_busy  = (state_q == S_DIV);

    // Divider state register and frequency tracking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            afreq_q <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            afreq_q <= afreq_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            bit_q   <= bit_d;
        end
    end

    // Start a division on a changed request, or go silent on zero.
    always_comb begin
        state_d = state_q;
        afreq_d = afreq_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        bit_d   = bit_q;
        done    = 1'b0;
        silence = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_freq == '0) begin
                    silence = 1'b1;
                    afreq_d = '0;
                end else if (i_freq != afreq_q) begin
                    afreq_d = i_freq;
                    dvs_d   = {i_freq, 1'b0};
                    rem_d   = '0;
                    dvd_d   = 32'(CLK_HZ);
                    bit_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = ge ? diff : shifted[DW-1:0];
                dvd_d = quo_raw;
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd31) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Tone phase registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hp_q     <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            o_pulse  <= 1'b0;
            o_tick   <= 1'b0;
        end else begin
            hp_q     <= hp_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            o_pulse  <= pulse_d;
            o_tick   <= tick_d;
        end
    end

    // New half periods land only when idle/muted or on a toggle.
    always_comb begin
        hp_d     = hp_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        pulse_d  = o_pulse;
        tick_d   = 1'b0;
        have_new = done | pend_v_q;
        new_val  = done ? result : pend_q;
        if (silence) begin
            hp_d     = '0;
            cnt_d    = '0;
            pulse_d  = 1'b0;
            pend_v_d = 1'b0;
        end else if (mute || hp_q == 32'd0) begin
            cnt_d   = '0;
            pulse_d = 1'b0;
            if (have_new) begin
                hp_d     = new_val;
                pend_v_d = 1'b0;
            end
        end else if (cnt_q == hp_q - 32'd1) begin
            pulse_d = ~o_pulse;
            tick_d  = ~o_pulse;
            cnt_d   = '0;
            if (have_new) begin
                hp_d     = new_val;
                pend_v_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 32'd1;
            if (done) begin
                pend_d   = result;
                pend_v_d = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed bench for audio_tone_gen at CLK_HZ=1000.
// Mute steps run only when AUDIO_TONE_GEN_MUTE_EN is defined.
module tb_audio_tone_gen;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    audio_tone_gen_if #(.FREQ_W(24)) ifc ();

    audio_tone_gen #(
        .CLK_HZ(1000),
        .FREQ_W(24)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_freq (ifc.freq),
`ifdef AUDIO_TONE_GEN_MUTE_EN
        .i_mute (ifc.mute),
`endif
        .o_pulse(ifc.pulse),
        .o_tick (ifc.tick),
        .o_busy (ifc.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (ifc.busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(tag, n, 32);
    endtask

    task automatic wait_rise(input string tag);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk({tag, "_low"}, {31'd0, ifc.pulse}, 0);
        end
        step();
        chk({tag, "_rise"}, {31'd0, ifc.pulse}, 1);
        chk({tag, "_tick"}, {31'd0, ifc.tick}, 1);
    endtask

    initial begin
        logic ep, et, eb;
        logic seen;
        int   q;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        ifc.freq = '0;
`ifdef AUDIO_TONE_GEN_MUTE_EN
        ifc.mute = 1'b0;
`endif
        #1;
        chk("rst_pulse", {31'd0, ifc.pulse}, 0);
        chk("rst_tick", {31'd0, ifc.tick}, 0);
        chk("rst_busy", {31'd0, ifc.busy}, 0);
        step();
        step();
        rst_n = 1'b1;
        ifc.freq = 24'd100;

        // 100 Hz: 32 busy cycles, then 5 high / 5 low
        step();
        chk("f100_busy", {31'd0, ifc.busy}, 1);
        wait_idle("f100_busylen");
        chk("f100_pulse0", {31'd0, ifc.pulse}, 0);
        wait_rise("f100_first");
        for (int i = 1; i <= 20; i++) begin
            step();
            ep = (i % 10) < 5;
            et = (i % 10) == 0;
            chk("f100_pulse", {31'd0, ifc.pulse}, {31'd0, ep});
            chk("f100_tick", {31'd0, ifc.tick}, {31'd0, et});
        end

        // silence mid-tone
        ifc.freq = '0;
        step();
        chk("sil_pulse", {31'd0, ifc.pulse}, 0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (ifc.pulse !== 1'b0 || ifc.busy !== 1'b0) seen = 1'b1;
        end
        chk("sil_quiet", {31'd0, seen}, 0);

        // 600 Hz clamps to half period 1
        ifc.freq = 24'd600;
        step();
        chk("f600_busy", {31'd0, ifc.busy}, 1);
        wait_idle("f600_busylen");
        chk("f600_pulse0", {31'd0, ifc.pulse}, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            ep = (i % 2) == 1;
            chk("f600_pulse", {31'd0, ifc.pulse}, {31'd0, ep});
            chk("f600_tick", {31'd0, ifc.tick}, {31'd0, ep});
        end

        // 100 -> 250 mid-tone, then 500 requested while busy
        ifc.freq = '0;
        step();
        chk("chg_sil", {31'd0, ifc.pulse}, 0);
        ifc.freq = 24'd100;
        step();
        wait_idle("chg_busylen");
        wait_rise("chg_first");
        ifc.freq = 24'd250;
        for (int p = 1; p <= 80; p++) begin
            step();
            if (p < 35) begin
                ep = (p % 10) < 5;
                et = (p % 10) == 0;
            end else if (p <= 67) begin
                q  = p - 35;
                ep = (q % 4) >= 2;
                et = (q % 4) == 2;
            end else begin
                ep = ((p - 67) % 2) == 1;
                et = ep;
            end
            eb = (p <= 32) || (p >= 34 && p <= 65);
            chk("chg_pulse", {31'd0, ifc.pulse}, {31'd0, ep});
            chk("chg_tick", {31'd0, ifc.tick}, {31'd0, et});
            chk("chg_busy", {31'd0, ifc.busy}, {31'd0, eb});
            if (p == 10) ifc.freq = 24'd500;
        end

        // reset mid-division
        ifc.freq = '0;
        step();
        ifc.freq = 24'd100;
        step();
        chk("rd_busy", {31'd0, ifc.busy}, 1);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("rd_busy0", {31'd0, ifc.busy}, 0);
        chk("rd_pulse0", {31'd0, ifc.pulse}, 0);
        chk("rd_tick0", {31'd0, ifc.tick}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rd_rebusy", {31'd0, ifc.busy}, 1);
        wait_idle("rd_busylen");
        wait_rise("rd_first");

        // reset mid-tone while pulse is high
        step();
        step();
        chk("rt_high", {31'd0, ifc.pulse}, 1);
        rst_n = 1'b0;
        #1;
        chk("rt_pulse0", {31'd0, ifc.pulse}, 0);
        chk("rt_tick0", {31'd0, ifc.tick}, 0);
        chk("rt_busy0", {31'd0, ifc.busy}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rt_rebusy", {31'd0, ifc.busy}, 1);
        wait_idle("rt_busylen");
        wait_rise("rt_first");

`ifdef AUDIO_TONE_GEN_MUTE_EN
        // mute for 20 cycles, tone restarts from phase zero
        ifc.mute = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ifc.pulse !== 1'b0 || ifc.tick !== 1'b0) seen = 1'b1;
        end
        chk("mute_quiet", {31'd0, seen}, 0);
        ifc.mute = 1'b0;
        wait_rise("mute_rel");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
